stopwatch_cmd_gen: RTL and testbench

//  Front-end command source for the millisecond stopwatch run flip-flop (FF_JK).

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/btn_debounce.sv | 60 ++++++
 rtl/stopwatch_cmd_gen.sv | 110 +++++++++++
 tb/tb_stopwatch_cmd_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch command front-end.
// Default timing assumes the 100 MHz board clock.
package stopwatch_pkg;

  localparam int CLK_HZ                    = 100_000_000;
  localparam int MS_CYCLES                 = 100_000;
  localparam int CNT_W_DEFAULT             = 28;
  localparam int DEBOUNCE_CYCLES_DEFAULT   = 1_000_000;
  localparam int LONG_PRESS_CYCLES_DEFAULT = 200_000_000;

  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: 2-FF synchronizer, persistence filter
// (a new level is accepted only after DEBOUNCE_CYCLES consecutive cycles
// of disagreement with the accepted level) and rising-edge detect.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_RAW,
  output logic LEVEL,
  output logic RISE
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             db_r;
  logic             db_q_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= BTN_RAW;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level only once it has persisted; any agreement restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      db_r   <= 1'b0;
      db_q_r <= 1'b0;
      cnt_r  <= CNT_ZERO;
    end else begin
      db_q_r <= db_r;
      if (sync2_r == db_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        db_r  <= sync2_r;
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign LEVEL = db_r;
  assign RISE  = db_r & ~db_q_r;

endmodule

// File: rtl/stopwatch_cmd_gen.sv
// START/STOP button front-end producing one-cycle J (start), K (stop) and
// optional CLR (long stop press) pulses for the stopwatch run flip-flop.
// Optional feature macro: LONG_PRESS_CLR_EN (long-press clear counter).
module stopwatch_cmd_gen
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT,
  parameter int CNT_W             = CNT_W_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_START,
  input  logic BTN_STOP,
  output logic J,
  output logic K,
  output logic CLR
);

  logic level_start_s;
  logic rise_start_s;
  logic level_stop_s;
  logic rise_stop_s;
  logic j_next_s;
  logic k_next_s;
  logic j_r;
  logic k_r;
  logic unused_s;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_start (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_RAW (BTN_START),
    .LEVEL   (level_start_s),
    .RISE    (rise_start_s)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_stop (
    .CLK     (CLK),
    .RST     (RST),
    .BTN_RAW (BTN_STOP),
    .LEVEL   (level_stop_s),
    .RISE    (rise_stop_s)
  );

  // Stop has priority: a simultaneous rise yields K only, so J and K never overlap.
  always_comb begin
    k_next_s = rise_stop_s;
    j_next_s = rise_start_s & ~rise_stop_s;
  end

  // Registered J/K pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      j_r <= 1'b0;
      k_r <= 1'b0;
    end else begin
      j_r <= j_next_s;
      k_r <= k_next_s;
    end
  end

  assign J = j_r;
  assign K = k_r;

`ifdef LONG_PRESS_CLR_EN
  localparam logic [CNT_W-1:0] HOLD_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] HOLD_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt_r;
  logic             hold_done_r;
  logic             clr_r;

  // Count how long STOP stays accepted; one CLR per press, re-armed by a release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt_r  <= HOLD_ZERO;
      hold_done_r <= 1'b0;
      clr_r       <= 1'b0;
    end else begin
      clr_r <= 1'b0;
      if (!level_stop_s) begin
        hold_cnt_r  <= HOLD_ZERO;
        hold_done_r <= 1'b0;
      end else if (hold_done_r) begin
        hold_cnt_r <= hold_cnt_r;
      end else if (hold_cnt_r == HOLD_LAST) begin
        clr_r       <= 1'b1;
        hold_done_r <= 1'b1;
      end else begin
        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
      end
    end
  end

  assign CLR      = clr_r;
  assign unused_s = level_start_s;
`else
  assign CLR      = 1'b0;
  assign unused_s = level_start_s ^ level_stop_s ^ (LONG_PRESS_CYCLES == 0);
`endif

endmodule

// File: tb/tb_stopwatch_cmd_gen.sv
// Bench for stopwatch_cmd_gen: directed segment table, hand-written bounce
// sequence and randomized buttons/reset checked cycle-by-cycle against a
// history-based reference model.
module tb_stopwatch_cmd_gen;

  localparam int D    = 4;
  localparam int LP   = 20;
  localparam int MAXE = 8192;

`ifdef LONG_PRESS_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic BTN_START;
  logic BTN_STOP;
  logic J;
  logic K;
  logic CLR;

  stopwatch_cmd_gen #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (LP),
    .CNT_W             (28)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_START (BTN_START),
    .BTN_STOP  (BTN_STOP),
    .J         (J),
    .K         (K),
    .CLR       (CLR)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Raw samples per edge; reset edges (and the one before) read as 0 because
  // the synchronizer is cleared. The accepted level flips when the last D
  // synchronized samples (raw delayed by 2 edges), all after the last reset,
  // disagree with it. Pulses appear one edge after the flip.
  bit hs [MAXE];
  bit hp [MAXE];
  int en       = 0;
  int last_rst = -1;
  bit lvl_s = 1'b0, lvl_p = 1'b0, rise_s = 1'b0, rise_p = 1'b0;
  int run_p = 0;
  bit exp_j = 1'b0, exp_k = 1'b0, exp_clr = 1'b0;

  function automatic bit synced(input bit side, input int n);
    if (n - 2 < 0) return 1'b0;
    return side ? hp[n-2] : hs[n-2];
  endfunction

  function automatic bit accept(input bit side, input int n, input bit lvl);
    for (int k = 0; k < D; k++) begin
      if (n - k <= last_rst) return 1'b0;
      if (synced(side, n - k) == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input bit s, input bit p, input bit r);
    hs[en] = s;
    hp[en] = p;
    if (r) begin
      hs[en] = 1'b0;
      hp[en] = 1'b0;
      if (en > 0) begin
        hs[en-1] = 1'b0;
        hp[en-1] = 1'b0;
      end
      last_rst = en;
      lvl_s = 1'b0; lvl_p = 1'b0; rise_s = 1'b0; rise_p = 1'b0;
      run_p = 0;
      exp_j = 1'b0; exp_k = 1'b0; exp_clr = 1'b0;
    end else begin
      exp_k   = rise_p;
      exp_j   = rise_s & ~rise_p;
      run_p   = lvl_p ? run_p + 1 : 0;
      exp_clr = CLR_EN && (run_p == LP);
      rise_s  = 1'b0;
      rise_p  = 1'b0;
      if (accept(1'b0, en, lvl_s)) begin
        lvl_s  = ~lvl_s;
        rise_s = lvl_s;
      end
      if (accept(1'b1, en, lvl_p)) begin
        lvl_p  = ~lvl_p;
        rise_p = lvl_p;
      end
    end
    en++;
  endtask

  // ---------------- segment bookkeeping ----------------
  int seg_idx, seg_j, seg_k, seg_clr, f_j, f_k, f_clr;

  task automatic seg_begin();
    seg_idx = 0; seg_j = 0; seg_k = 0; seg_clr = 0;
    f_j = 0; f_k = 0; f_clr = 0;
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit s, input bit p, input bit r);
    BTN_START = s;
    BTN_STOP  = p;
    RST       = r;
    @(posedge CLK);
    model_edge(s, p, r);
    #1;
    seg_idx++;
    if (J)   begin seg_j++;   if (f_j == 0)   f_j = seg_idx;   end
    if (K)   begin seg_k++;   if (f_k == 0)   f_k = seg_idx;   end
    if (CLR) begin seg_clr++; if (f_clr == 0) f_clr = seg_idx; end
    check($sformatf("cycle%0d {J,K,CLR}", en), int'({J, K, CLR}),
          int'({exp_j, exp_k, exp_clr}));
  endtask

  typedef struct {
    bit rst; bit start; bit stop; int cycles;
    int n_j; int n_k; int n_clr; int f_j; int f_k; int f_clr;
  } seg_t;

  function automatic seg_t mk(input bit r, input bit s, input bit p, input int c,
                              input int nj, input int nk, input int nc,
                              input int fj, input int fk, input int fc);
    seg_t t;
    t.rst = r; t.start = s; t.stop = p; t.cycles = c;
    t.n_j = nj; t.n_k = nk; t.n_clr = nc; t.f_j = fj; t.f_k = fk; t.f_clr = fc;
    return t;
  endfunction

  seg_t tbl [12];

  initial begin
    int hold_s, hold_p;
    bit rs, rp, rr;

    tbl[0]  = mk(1, 0, 0,  5, 0, 0, 0, 0, 0, 0);              // reset, idle
    tbl[1]  = mk(0, 0, 0, 10, 0, 0, 0, 0, 0, 0);              // idle after reset
    tbl[2]  = mk(0, 1, 0, 20, 1, 0, 0, 7, 0, 0);              // clean start press
    tbl[3]  = mk(0, 0, 0, 10, 0, 0, 0, 0, 0, 0);              // release: no pulse
    tbl[4]  = mk(0, 1, 1, 10, 0, 1, 0, 0, 7, 0);              // simultaneous: stop wins
    tbl[5]  = mk(0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 40, 0, 1, CLR_EN ? 1 : 0,
                 0, 7, CLR_EN ? 26 : 0);                       // long stop hold
    tbl[7]  = mk(0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0,  4, 0, 0, 0, 0, 0, 0);              // mid-debounce
    tbl[9]  = mk(1, 1, 0,  1, 0, 0, 0, 0, 0, 0);              // reset while held
    tbl[10] = mk(0, 1, 0, 20, 1, 0, 0, 7, 0, 0);              // re-qualify from zero
    tbl[11] = mk(0, 0, 0, 10, 0, 0, 0, 0, 0, 0);

    BTN_START = 1'b0;
    BTN_STOP  = 1'b0;
    RST       = 1'b1;

    for (int i = 0; i < 12; i++) begin
      seg_begin();
      for (int c = 0; c < tbl[i].cycles; c++) step(tbl[i].start, tbl[i].stop, tbl[i].rst);
      check($sformatf("seg%0d J count", i),   seg_j,   tbl[i].n_j);
      check($sformatf("seg%0d K count", i),   seg_k,   tbl[i].n_k);
      check($sformatf("seg%0d CLR count", i), seg_clr, tbl[i].n_clr);
      check($sformatf("seg%0d J first", i),   f_j,     tbl[i].f_j);
      check($sformatf("seg%0d K first", i),   f_k,     tbl[i].f_k);
      check($sformatf("seg%0d CLR first", i), f_clr,   tbl[i].f_clr);
    end

    // STOP bouncing every 2 cycles never qualifies
    seg_begin();
    for (int c = 0; c < 30; c++) step(1'b0, ((c / 2) % 2) == 0, 1'b0);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0);
    check("bounce K count", seg_k, 0);
    check("bounce J count", seg_j, 0);

    // followed by a clean hold: exactly one K
    seg_begin();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 1'b0);
    check("clean stop K count", seg_k, 1);
    check("clean stop K first", f_k, 7);
    check("clean stop J count", seg_j, 0);
    seg_begin();
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0);
    check("stop release K count", seg_k, 0);

    // randomized buttons with variable hold lengths and rare resets
    hold_s = 0; hold_p = 0; rs = 1'b0; rp = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (hold_s == 0) begin
        rs = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 30);
      end
      if (hold_p == 0) begin
        rp = 1'($urandom_range(0, 1));
        hold_p = $urandom_range(1, 30);
      end
      hold_s--;
      hold_p--;
      rr = ($urandom_range(0, 299) == 0);
      step(rs, rp, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
